// File: rtl/dmem_arbiter.sv
// Purpose: two-port (CPU port C, debug port D) arbiter and sequencer for the single-ported data memory.
// Latency: request sampled in IDLE at T -> mem_en at T+1 -> ack at T+2+MEM_LAT; one transaction in flight.
// Backpressure: requesters hold req until ack; the losing port simply waits; halt blocks new C grants.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   halt            core halted; C port is not granted while high
//   c_* / d_*       req/we/addr/wdata in, ack pulse and held rdata out, one set per port
//   mem_*           memory strobe, write enable, address, write data out; read data in
//   busy, owner     transaction in flight; current/last grantee (0 = C, 1 = D)
module dmem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  // MEM_LAT is limited to 1..4, so the remaining-latency count fits in 2 bits.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               last_q;
  logic               owner_q;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      c_rdata_q;
  logic [DW-1:0]      d_rdata_q;

  logic               ec;
  logic               ed;
  logic               grant;
  logic               pick_d;

  // Next-state and grant decision.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    pick_d  = 1'b0;
    ec      = c_req & ~halt;
    ed      = d_req;
    case (state_q)
      IDLE: begin
        if (ec || ed) begin
          grant   = 1'b1;
          // On a tie the port that did not win last time gets the grant.
          pick_d  = ed & (~ec | ~last_q);
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;

      // Winner's command is latched at grant; later changes on its inputs are ignored.
      if (grant) begin
        owner_q <= pick_d;
        last_q  <= pick_d;
        we_q    <= pick_d ? d_we    : c_we;
        addr_q  <= pick_d ? d_addr  : c_addr;
        wdata_q <= pick_d ? d_wdata : c_wdata;
      end

      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(MEM_LAT - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      // Last WAIT cycle is exactly MEM_LAT cycles after the mem_en cycle.
      if (state_q == WAIT && cnt_q == '0 && !we_q) begin
        if (owner_q) d_rdata_q <= mem_rdata;
        else         c_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_ack     = (state_q == DONE) & ~owner_q;
  assign d_ack     = (state_q == DONE) &  owner_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer for the CPU's single-ported data memory (data_memory).
- Port C is the CPU load/store path.
- Port D is the debug/loader path; it preloads and inspects memory while the core is halted.
- One transaction is in flight at a time. Ties are resolved round-robin. The halt input masks the CPU port so the debug path owns memory during halt.

Parameters:
AW, 8, address width in bits.
DW, 16, data width in bits.
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..4.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
halt  in  1  core halted; masks new grants to port C.
c_req  in  1  CPU request; held until c_ack.
c_we  in  1  CPU write enable (1 = store, 0 = load).
c_addr  in  AW  CPU address.
c_wdata  in  DW  CPU store data.
c_ack  out  1  one-cycle completion pulse to the CPU.
c_rdata  out  DW  CPU load data; valid with c_ack, held until the next C read completes.
d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug request; same semantics as port C.
d_ack  out  1  one-cycle completion pulse to debug.
d_rdata  out  DW  debug load data; same semantics as c_rdata.
mem_en  out  1  memory access strobe, one cycle per transaction.
mem_we  out  1  memory write enable; qualified by mem_en.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.
busy  out  1  transaction in flight (ISSUE, WAIT or DONE).
owner  out  1  current/last grantee: 0 = C, 1 = D.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Round-robin pointer last = 1, so C wins the first tie.
  - Lat counter = 0.
  - Any in-flight transaction is dropped with no ack.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Effective requests are ec = c_req & ~halt and ed = d_req.
  - Only ec: grant C. Only ed: grant D. Both: grant the port != last.
  - On grant, register we/addr/wdata from the winner, set owner, set last = winner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1, with mem_we/mem_addr/mem_wdata driven from the registers.
  - Load counter = MEM_LAT - 1, go to WAIT.
- WAIT:
  - While counter != 0, decrement.
  - When counter == 0, go to DONE; that clock edge captures mem_rdata into the owner's rdata register (reads only).
- DONE (1 cycle):
  - The owner's ack = 1. No sampling of requests. Next state IDLE.
- Latency: the request sampled in IDLE at cycle T gives mem_en at T+1 and ack at T+2+MEM_LAT.
  - Minimum spacing between grants is MEM_LAT+3 cycles.
- Requester contract:
  - Requesters drop req at or after the ack edge; a req still high in the cycle after ack is treated as a new request.
  - Changes to req, we, addr or wdata after grant are ignored; the transaction completes and acks regardless.
- Writes use the same timing and return an ack; the rdata registers are unchanged by writes.
- mem_en is 0 outside ISSUE. mem_addr/mem_we/mem_wdata hold their last values.
- halt:
  - Asserting halt mid C-transaction does not abort it; it completes with c_ack.
  - While halt=1, C is never granted and D is granted without waiting on C.
  - Deasserting halt re-enables C at the next IDLE sample.
- c_ack and d_ack are never high in the same cycle.

Test Plan:
- MEM_LAT=2, reset, then C load addr 0x05 with memory[5]=0x1234 at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x05 at cycle 1; c_ack pulse at cycle 4 with c_rdata=0x1234; d_ack stays 0.
- C and D both request in the same IDLE cycle after reset -> C granted first (owner=0). With both held high, the next grant goes to D, then C again: strict alternation of c_ack/d_ack.
- halt=1, C and D both requesting -> only D is served (repeated d_ack). Drop halt -> C granted at the next IDLE.
- D store addr 0x07 data 0xBEEF, then C load 0x07 -> mem_we=1 on the D ISSUE cycle; c_rdata=0xBEEF; d_rdata unchanged by the store.
- Drive rst=0 asynchronously during WAIT of a C load -> busy, mem_en and c_ack drop immediately; no ack after release; the next tie goes to C.
- MEM_LAT=1 and MEM_LAT=4 sweep -> ack at T+3 and T+6 respectively; mem_rdata is captured on the correct edge.
